// File: rtl/mem_access_unit.sv
// Data-memory access stage: turns decoder store/load codes into a single
// req/ack bus transaction, stalls the pipeline while the transaction is
// outstanding and returns aligned, extended load data. Misaligned accesses
// never reach the bus, and an unanswered request is aborted after TIMEOUT
// REQ cycles. Both cases are reported as a one-cycle err pulse.
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  LAddr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata_out,
    output logic        stall,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       ltype_r;
    logic [1:0]       off_r;

    logic             is_write_s;
    logic             is_read_s;
    logic             acc_s;
    logic             aligned_s;
    logic [3:0]       be_s;
    logic [31:0]      wd_s;

    // Select the addressed byte or halfword lane and sign/zero-extend it.
    function automatic logic [31:0] extend_load(input logic [2:0]  ltype,
                                                input logic [1:0]  off,
                                                input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[{off, 3'b000} +: 8];
        h = off[1] ? data[31:16] : data[15:0];
        case (ltype)
            3'b001:  extend_load = {{24{b[7]}}, b};
            3'b010:  extend_load = {24'h000000, b};
            3'b011:  extend_load = {{16{h[15]}}, h};
            3'b100:  extend_load = {16'h0000, h};
            default: extend_load = data;
        endcase
    endfunction

    // Decode the access: the store wins over a simultaneous load strobe.
    always_comb begin
        is_write_s = (MemWrite != 2'b00);
        is_read_s  = MemRead & ~is_write_s;
        acc_s      = is_write_s | is_read_s;
        aligned_s  = 1'b1;
        be_s       = 4'b1111;
        wd_s       = 32'h00000000;
        if (is_write_s) begin
            case (MemWrite)
                2'b01: begin
                    aligned_s = (addr[1:0] == 2'b00);
                    be_s      = 4'b1111;
                    wd_s      = wdata;
                end
                2'b10: begin
                    aligned_s = 1'b1;
                    be_s      = 4'b0001 << addr[1:0];
                    wd_s      = {4{wdata[7:0]}};
                end
                2'b11: begin
                    aligned_s = ~addr[0];
                    be_s      = addr[1] ? 4'b1100 : 4'b0011;
                    wd_s      = {2{wdata[15:0]}};
                end
                default: begin
                    aligned_s = 1'b1;
                    be_s      = 4'b1111;
                    wd_s      = 32'h00000000;
                end
            endcase
        end else begin
            case (LAddr)
                3'b001, 3'b010: aligned_s = 1'b1;
                3'b011, 3'b100: aligned_s = ~addr[0];
                default:        aligned_s = (addr[1:0] == 2'b00);
            endcase
        end
    end

    // Stall is raised in the issuing IDLE cycle already, so the PC freezes
    // before the request is even on the bus.
    always_comb begin
        stall = 1'b0;
        if (!rstn) begin
            stall = 1'b0;
        end else begin
            case (state_r)
                IDLE:    stall = acc_s & aligned_s;
                REQ:     stall = 1'b1;
                DONE:    stall = 1'b0;
                default: stall = 1'b0;
            endcase
        end
    end

    // Access sequencer with registered bus and result outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            ltype_r   <= 3'b000;
            off_r     <= 2'b00;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= 4'b0000;
            bus_addr  <= 32'h00000000;
            bus_wdata <= 32'h00000000;
            rdata_out <= 32'h00000000;
            err       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (acc_s && aligned_s) begin
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_we    <= is_write_s;
                        bus_be    <= be_s;
                        bus_wdata <= wd_s;
                        ltype_r   <= LAddr;
                        off_r     <= addr[1:0];
                        cnt_r     <= '0;
                        bus_req   <= 1'b1;
                        err       <= 1'b0;
                        state_r   <= REQ;
                    end else if (acc_s) begin
                        err       <= 1'b1;
                        rdata_out <= 32'h00000000;
                    end else begin
                        err       <= 1'b0;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            rdata_out <= extend_load(ltype_r, off_r, bus_rdata);
                        end
                        state_r <= DONE;
                    end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                        bus_req   <= 1'b0;
                        err       <= 1'b1;
                        rdata_out <= 32'h00000000;
                        state_r   <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                DONE: begin
                    err     <= 1'b0;
                    cnt_r   <= '0;
                    state_r <= IDLE;
                end
                default: begin
                    bus_req <= 1'b0;
                    err     <= 1'b0;
                    cnt_r   <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage sitting directly downstream of the main decoder. Consumes the decoder's store-type code MemWrite[1:0], load-type code LAddr[2:0] and a load strobe, plus the ALU address and rt data.
- Drives a req/ack data-memory bus with word-aligned address, byte enables and lane-replicated store data. Returns aligned, sign/zero-extended load data to the write-back mux.
- Stalls the PC while an access is in flight. Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16: maximum REQ cycles without bus_ack before the access is aborted; must be ≥1.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- MemWrite  in  2  decoder store code: 00 none, 01 sw, 10 sb, 11 sh.
- MemRead  in  1  load strobe (high when the write-back select is FromMEM).
- LAddr  in  3  load type: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; 101–111 treated as lw.
- addr  in  32  effective byte address from the ALU.
- wdata  in  32  store data (rt).
- rdata_out  out  32  extended load result; valid in DONE.
- stall  out  1  freeze PC/IR.
- err  out  1  one-cycle pulse on misalignment or timeout.
- bus_req  out  1  bus request.
- bus_we  out  1  write enable.
- bus_be  out  4  byte enables; bit i selects byte lane [8i+7:8i].
- bus_addr  out  32  {addr[31:2],2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read data; valid when bus_ack is high.
- bus_ack  in  1  single-cycle completion.

Behaviour:
- Reset (rstn low at an edge): state←IDLE, counter←0. bus_req, bus_we, bus_be, bus_addr, bus_wdata, rdata_out and err all ←0. stall is forced 0 while rstn is low.
- Reset mid-access: abort immediately. bus_req is low from the next cycle; no completion is reported.
- Access request: acc = (MemWrite≠00) | MemRead. If MemWrite≠00 and MemRead are both set, the write wins and the read is ignored.
- Alignment: sw/lw require addr[1:0]=00; sh/lh/lhu require addr[0]=0; byte accesses are always aligned.
- IDLE, acc and aligned: stall=1 combinationally. Register bus_addr, bus_we, bus_be and bus_wdata; capture LAddr and addr[1:0]. Next state REQ.
- IDLE, acc and misaligned: no bus access, stall=0. Next cycle err=1 and rdata_out=0; state stays IDLE.
- IDLE, no acc: stall=0, err=0.
- REQ: bus_req=1, stall=1, bus outputs held stable.
  - On bus_ack: capture the extended bus_rdata (reads) into rdata_out; next state DONE.
  - Without ack: counter increments. When the counter reaches TIMEOUT-1 with no ack: next state DONE with err=1 and rdata_out=0; bus_req drops.
- DONE: stall=0, bus_req=0, rdata_out valid. The CPU advances at this edge; next state IDLE and counter←0. err is high only in DONE after a timeout, and for the one IDLE cycle after a misaligned access.
- Minimum latency with ack in the first REQ cycle: 3 cycles per access (IDLE, REQ, DONE).
- Byte enables:
  - sw: 1111.
  - sh: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - sb: one-hot 1<<addr[1:0].
  - reads: 1111.
- Store data:
  - sw: wdata.
  - sh: {wdata[15:0],wdata[15:0]}.
  - sb: {4{wdata[7:0]}}.
- Load extraction by the captured addr[1:0]:
  - byte = lane addr[1:0]; half = lanes [15:0] or [31:16] by addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes bus_rdata through.
- A bus_ack arriving outside REQ is ignored.

Test Plan:
- lw, addr=0x0000_0104, bus_rdata=0xDEADBEEF, ack in the first REQ cycle. Required: bus_addr=0x104, bus_be=1111, bus_we=0; stall high for 2 cycles; rdata_out=0xDEADBEEF in DONE.
- lb addr=0x103 and lbu addr=0x103, bus_rdata=0x80FF_0011. Required: lb rdata_out=0xFFFF_FF80; lbu rdata_out=0x0000_0080.
- lh addr=0x102, bus_rdata=0x8001_7FFF. Required: rdata_out=0xFFFF_8001. sh addr=0x102, wdata=0x1234_ABCD. Required: bus_be=1100, bus_wdata=0xABCD_ABCD, bus_we=1.
- sb addr=0x201, wdata=0x55, with MemRead also high. Required: write only, bus_be=0010, bus_wdata=0x5555_5555. sw addr=0x202. Required: no bus_req, err pulse, stall never asserted.
- lw with bus_ack held low (TIMEOUT=16). Required: bus_req high exactly 16 cycles, then DONE with err=1, rdata_out=0, stall=0.
- rstn pulsed low during REQ of a sw. Required: bus_req=0 and state IDLE the following cycle, all outputs 0. A late bus_ack produces no rdata_out update.
